// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, counter sizing and per-sample action type for the debounce bank
//
// Contents:
//   MAX_CH, MIN_STABLE, MAX_STABLE  legal parameter bounds
//   chan_act_e                      what one channel does on a given clock
//   cnt_width()                     width of a counter that must reach STABLE_CYCLES-1 without wrapping
//   params_legal()                  elaboration-time legality check for the bank parameters

package debounce_pkg;

   localparam int MIN_CH     = 1;
   localparam int MAX_CH     = 32;
   localparam int MIN_STABLE = 1;
   localparam int MAX_STABLE = 65535;

   // Decoded per-clock behaviour of a channel; keeps the counter and level
   // update logic a simple case on one signal.
   typedef enum logic [1:0] {
      ACT_HOLD   = 2'd0,   // no sample this cycle
      ACT_CLEAR  = 2'd1,   // sample agrees with the accepted level
      ACT_COUNT  = 2'd2,   // sample disagrees, run not yet long enough
      ACT_TOGGLE = 2'd3    // sample disagrees and completes the run
   } chan_act_e;

   // Sized one step beyond STABLE_CYCLES so the compare value always fits.
   function automatic int cnt_width(input int stable_cycles);
      return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
   endfunction

   function automatic bit params_legal(input int n_ch, input int stable_cycles);
      return (n_ch >= MIN_CH) && (n_ch <= MAX_CH) &&
             (stable_cycles >= MIN_STABLE) && (stable_cycles <= MAX_STABLE);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounced channel: synchroniser, run counter, accepted level, edge pulses
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sample_en  take a sample this cycle
//   raw        asynchronous raw input
//   level      accepted (debounced) level, registered
//   rise       one-cycle pulse on level 0->1
//   fall       one-cycle pulse on level 1->0
//   toggle     combinational: level will flip on this edge (feeds the bank-wide any_edge flop)

module debounce_chan
   import debounce_pkg::*;
#(
   parameter int   STABLE_CYCLES = 4,
   parameter logic RESET_BIT     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic toggle
);

   localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             meta;
   logic             sync;
   logic [CNT_W-1:0] cnt;
   chan_act_e        act;

   // Both stages reset to the channel's reset level so a raw input already
   // sitting at that level never looks like a transition after reset.
   // These flops run every clock regardless of sample_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_BIT;
         sync <= RESET_BIT;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // The counter holds the number of consecutive disagreeing samples already
   // seen, so the run completes when it reads STABLE_CYCLES-1 and the current
   // sample also disagrees. With STABLE_CYCLES=1 CNT_LAST is 0 and the first
   // disagreeing sample toggles.
   always_comb begin
      act = ACT_HOLD;
      if (sample_en) begin
         if (sync == level) begin
            act = ACT_CLEAR;
         end else if (cnt == CNT_LAST) begin
            act = ACT_TOGGLE;
         end else begin
            act = ACT_COUNT;
         end
      end
   end

   assign toggle = (act == ACT_TOGGLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= RESET_BIT;
      end else begin
         case (act)
            ACT_CLEAR: begin
               cnt <= '0;
            end
            ACT_COUNT: begin
               cnt <= cnt + CNT_ONE;
            end
            ACT_TOGGLE: begin
               cnt   <= '0;
               level <= ~level;
            end
            default: begin
               cnt   <= cnt;
               level <= level;
            end
         endcase
      end
   end

   // Pulses are registered on the same edge as the level flip; the pre-flip
   // level decides the direction, so rise and fall are mutually exclusive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= toggle & ~level;
         fall <= toggle & level;
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of N_CH independent debounced inputs with edge pulses
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   sample_en  sample strobe (tie high to sample every clock)
//   in         raw asynchronous inputs, N_CH bits
//   out        debounced levels, registered
//   rise       one-cycle pulse per channel on out 0->1
//   fall       one-cycle pulse per channel on out 1->0
//   any_edge   registered OR of all rise/fall, aligned with those pulses

module debounce_bank
   import debounce_pkg::*;
#(
   parameter int              N_CH          = 4,
   parameter int              STABLE_CYCLES = 4,
   parameter logic [N_CH-1:0] RESET_VAL     = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sample_en,
   input  logic [N_CH-1:0] in,
   output logic [N_CH-1:0] out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            any_edge
);

   if (!params_legal(N_CH, STABLE_CYCLES)) begin : g_bad_params
      $fatal(1, "debounce_bank: N_CH must be 1..32 and STABLE_CYCLES 1..65535");
   end

   logic [N_CH-1:0] toggle;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      debounce_chan #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RESET_BIT     (RESET_VAL[i])
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .sample_en (sample_en),
         .raw       (in[i]),
         .level     (out[i]),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .toggle    (toggle[i])
      );
   end

   // Registered from the channels' pre-edge toggle terms so it lands on the
   // same edge as the rise/fall flops rather than one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_edge <= 1'b0;
      end else begin
         any_edge <= |toggle;
      end
   end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank (STABLE_CYCLES=4 and STABLE_CYCLES=1 builds)

module tb_debounce_bank;

   localparam logic [3:0] RESET_A = 4'b0000;
   localparam logic [3:0] RESET_B = 4'b0101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_en;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [3:0] out_a, rise_a, fall_a;
   logic [3:0] out_b, rise_b, fall_b;
   logic       any_a, any_b;

   always #5 clk = ~clk;

   debounce_bank #(
      .N_CH          (4),
      .STABLE_CYCLES (4),
      .RESET_VAL     (RESET_A)
   ) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .in        (in_a),
      .out       (out_a),
      .rise      (rise_a),
      .fall      (fall_a),
      .any_edge  (any_a)
   );

   debounce_bank #(
      .N_CH          (4),
      .STABLE_CYCLES (1),
      .RESET_VAL     (RESET_B)
   ) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .in        (in_b),
      .out       (out_b),
      .rise      (rise_b),
      .fall      (fall_b),
      .any_edge  (any_b)
   );

   // Expected {out, rise, fall, any_edge} after each rising edge.
   string       q_name[$];
   logic [12:0] q_a[$];
   logic [12:0] q_b[$];

   int vectors = 0;
   int errors  = 0;

   logic [3:0] eo_a = RESET_A;
   logic [3:0] eo_b = RESET_B;

   // Apply one input pattern for n cycles. ev_a / ev_b give the edge index
   // (1 = first rising edge after the inputs change) at which a hand-computed
   // transition is expected, with its rise/fall masks; 0 means none.
   task automatic run(input string name, input logic rst, input int per,
                      input logic [3:0] va, input logic [3:0] vb, input int n,
                      input int ev_a, input logic [3:0] r_a, input logic [3:0] f_a,
                      input int ev_b, input logic [3:0] r_b, input logic [3:0] f_b);
      logic [3:0] er_a, ef_a, er_b, ef_b;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         rst_n     = rst;
         sample_en = ((k % per) == 0);
         in_a      = va;
         in_b      = vb;
         er_a = '0; ef_a = '0; er_b = '0; ef_b = '0;
         if (!rst) begin
            eo_a = RESET_A;
            eo_b = RESET_B;
         end else begin
            if (k == ev_a) begin
               er_a = r_a;
               ef_a = f_a;
               eo_a = eo_a ^ (r_a | f_a);
            end
            if (k == ev_b) begin
               er_b = r_b;
               ef_b = f_b;
               eo_b = eo_b ^ (r_b | f_b);
            end
         end
         q_name.push_back($sformatf("%s/%0d", name, k));
         q_a.push_back({eo_a, er_a, ef_a, |(er_a | ef_a)});
         q_b.push_back({eo_b, er_b, ef_b, |(er_b | ef_b)});
      end
   endtask

   // Monitor: compares once per clock, after the edge has settled.
   initial begin
      string       nm;
      logic [12:0] ea, eb, aa, ab;
      forever begin
         @(posedge clk);
         #1;
         if (q_a.size() > 0) begin
            nm = q_name.pop_front();
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            aa = {out_a, rise_a, fall_a, any_a};
            ab = {out_b, rise_b, fall_b, any_b};
            vectors++;
            if (aa !== ea) begin
               errors++;
               $display("FAIL %s stable4 out/rise/fall/any got %b_%b_%b_%b want %b_%b_%b_%b",
                        nm, aa[12:9], aa[8:5], aa[4:1], aa[0], ea[12:9], ea[8:5], ea[4:1], ea[0]);
            end
            vectors++;
            if (ab !== eb) begin
               errors++;
               $display("FAIL %s stable1 out/rise/fall/any got %b_%b_%b_%b want %b_%b_%b_%b",
                        nm, ab[12:9], ab[8:5], ab[4:1], ab[0], eb[12:9], eb[8:5], eb[4:1], eb[0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      sample_en = 1'b1;
      in_a      = RESET_A;
      in_b      = RESET_B;

      //   name           rst per  in_a     in_b     n   ev  rise_a   fall_a   evb rise_b   fall_b
      run("reset",        0,  1, 4'b0000, RESET_B,  3,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("rise_one",     1,  1, 4'b0001, RESET_B, 10,  6, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
      run("fall_one",     1,  1, 4'b0000, RESET_B, 10,  6, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000);
      run("glitch3",      1,  1, 4'b0001, RESET_B,  3,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("glitch3_end",  1,  1, 4'b0000, RESET_B, 10,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("pulse4",       1,  1, 4'b0001, RESET_B,  4,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("pulse4_end",   1,  1, 4'b0000, RESET_B,  2,  2, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000);
      run("pulse4_fall",  1,  1, 4'b0000, RESET_B,  8,  4, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000);
      run("all_rise",     1,  1, 4'b1111, RESET_B, 10,  6, 4'b1111, 4'b0000, 0, 4'b0000, 4'b0000);
      run("all_fall",     1,  1, 4'b0000, RESET_B, 10,  6, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000);
      run("two_rise",     1,  1, 4'b0011, RESET_B, 10,  6, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000);
      run("mixed",        1,  1, 4'b1010, RESET_B, 10,  6, 4'b1000, 4'b0001, 0, 4'b0000, 4'b0000);
      run("mixed_fall",   1,  1, 4'b0000, RESET_B, 10,  6, 4'b0000, 4'b1010, 0, 4'b0000, 4'b0000);
      run("strobe3",      1,  3, 4'b0100, RESET_B, 15, 12, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000);
      run("strobe_fall",  1,  1, 4'b0000, RESET_B, 10,  6, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000);
      run("rst_mid",      1,  1, 4'b0010, RESET_B,  4,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("rst_hold",     0,  1, 4'b0010, RESET_B,  2,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("rst_release",  1,  1, 4'b0010, RESET_B, 10,  6, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000);
      run("rst_fall",     1,  1, 4'b0000, RESET_B, 10,  6, 4'b0000, 4'b0010, 0, 4'b0000, 4'b0000);
      run("rst_discard",  1,  1, 4'b0001, RESET_B,  3,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("rst_disc_low", 0,  1, 4'b0000, RESET_B,  2,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("rst_quiet",    1,  1, 4'b0000, RESET_B, 10,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);
      run("s1_up_a",      1,  1, 4'b0000, 4'b1101,  4,  0, 4'b0000, 4'b0000, 3, 4'b1000, 4'b0000);
      run("s1_dn_a",      1,  1, 4'b0000, 4'b0101,  4,  0, 4'b0000, 4'b0000, 3, 4'b0000, 4'b1000);
      run("s1_up_b",      1,  1, 4'b0000, 4'b1101,  4,  0, 4'b0000, 4'b0000, 3, 4'b1000, 4'b0000);
      run("s1_dn_b",      1,  1, 4'b0000, 4'b0101,  4,  0, 4'b0000, 4'b0000, 3, 4'b0000, 4'b1000);
      run("settle",       1,  1, 4'b0000, 4'b0101,  3,  0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000);

      repeat (2) @(negedge clk);
      vectors++;
      if (q_a.size() != 0) begin
         errors++;
         $display("FAIL drain scoreboard entries left got %0d want 0", q_a.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive differing samples needed to accept a new level, legal range 1..65535.
REQ-003 Parameter RESET_VAL, default 0 (N_CH bits): per-channel level loaded at reset.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 sample_en  input  1  sample strobe; 1 = take a sample this cycle (tie high for per-clock sampling).
REQ-007 in  input  N_CH  raw, asynchronous channel inputs (buttons/switches).
REQ-008 out  output  N_CH  debounced level per channel, registered.
REQ-009 rise  output  N_CH  one-cycle pulse when out[i] goes 0->1.
REQ-010 fall  output  N_CH  one-cycle pulse when out[i] goes 1->0.
REQ-011 any_edge  output  1  registered OR of all rise and fall bits, same cycle as those pulses.

Function
REQ-012 Each in[i] SHALL pass through a 2-flop synchroniser; the second stage (sync[i]) is the only value used downstream.
REQ-013 Synchroniser flops SHALL clock every cycle, independent of sample_en.
REQ-014 Per channel: a counter of width CNT_W = clog2(STABLE_CYCLES+1), localparam, never wraps.
REQ-015 On a cycle with sample_en=1 and sync[i]==out[i]: counter clears to 0; out unchanged.
REQ-016 On a cycle with sample_en=1 and sync[i]!=out[i] and counter<STABLE_CYCLES-1: counter increments by 1.
REQ-017 On a cycle with sample_en=1 and sync[i]!=out[i] and counter==STABLE_CYCLES-1: out[i] toggles, counter clears, rise[i] or fall[i] asserts on the same edge.
REQ-018 On a cycle with sample_en=0: counters, out, and state hold; rise/fall/any_edge are 0.
REQ-019 rise/fall SHALL be high for exactly one clk cycle per accepted transition; rise[i] and fall[i] are never high together.
REQ-020 Latency with sample_en held 1: out[i] updates on the (STABLE_CYCLES+2)th rising edge after in[i] changes and holds.
REQ-021 Any glitch yielding fewer than STABLE_CYCLES consecutive differing samples SHALL leave out[i] unchanged and produce no pulse.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on several channels each produce their own pulse in the same cycle.
REQ-023 STABLE_CYCLES=1: out follows sync on the first differing sample (latency 3 edges).

Reset
REQ-024 While rst_n=0: out=RESET_VAL, both synchroniser stages=RESET_VAL, counters=0, rise=fall=0, any_edge=0, asynchronously.
REQ-025 Reset asserted mid-count SHALL discard the partial count; no pulse issued on or after deassertion if in equals RESET_VAL.
REQ-026 After deassertion, the first accepted transition follows REQ-020 timing from the first rising edge.

Structure
REQ-027 Shared package debounce_pkg SHALL hold the counter-width function and the maximum-channel/maximum-STABLE_CYCLES legality constants.
REQ-028 One sub-module debounce_chan (synchroniser, counter, level, pulse for one channel) SHALL be instantiated N_CH times via a generate loop; top level adds only any_edge.
REQ-029 Illegal parameters SHALL be rejected at elaboration.

Verification (N_CH=4, STABLE_CYCLES=4, RESET_VAL=0, sample_en=1 unless stated)
REQ-030 in=4'b0001 held from edge 1 -> out=4'b0001 and rise=4'b0001 for one cycle at edge 6; no pulse otherwise.
REQ-031 in[0] high for 3 cycles then low -> out stays 0, rise/fall stay 0.
REQ-032 in=4'b1111 held, then all low after out=1111 -> rise=1111 at edge 6, later fall=1111 once; any_edge high exactly on those two cycles.
REQ-033 sample_en pulsed every 3rd cycle, in[2] held high -> out[2] rises after 4 sample strobes plus 2 sync edges; no change between strobes.
REQ-034 rst_n driven low after 2 qualifying samples of in[1]=1, released with in[1]=1 -> counter restarts; out[1] rises 6 edges after release, single rise pulse.
REQ-035 STABLE_CYCLES=1 build, in[3] toggles every 4 cycles -> out[3] tracks with 3-edge latency, one pulse per toggle.
